// File: rtl/rr_sel4_if.sv
// Request/select bundle between the rr_sel4 arbiter and the consumer of the mux4 datapath.
// The master (arbiter) drives the selection; the slave supplies requests and accepts the selection.
interface rr_sel4_if;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] s;
  logic [3:0] grant;
  logic       out_valid;
  logic       timeout;

  modport master (
    input  req,
    input  out_ready,
    output s,
    output grant,
    output out_valid,
    output timeout
  );

  modport slave (
    output req,
    output out_ready,
    input  s,
    input  grant,
    input  out_valid,
    input  timeout
  );
endinterface

// File: rtl/rr_sel4.sv
// Round-robin select generator for a 4:1 mux, with a valid/ready handshake on the selection
// and an optional timeout that releases a grant whose consumer never accepts it.
module rr_sel4 #(
  parameter int TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_sel4_if.master bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam int             TO_M1   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [7:0]     TO_LAST = 8'(TO_M1);

  state_t     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  // Scan last+1, last+2, last+3, last; iterating backwards lets the nearest hit win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = l;
    for (int k = 4; k >= 1; k--) begin
      idx = l + k[1:0];
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= 2'd0;
      grant_q    <= 4'd0;
      last_q     <= 2'd3;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Handshake is tested before the timeout so a simultaneous accept never reports a timeout.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    grant_d    = grant_q;
    last_d     = last_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_d = 4'd0;
        if (bus.req != 4'd0) begin
          s_d        = rr_pick(bus.req, last_q);
          grant_d    = 4'd1 << s_d;
          wait_cnt_d = 8'd0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (bus.out_ready) begin
          last_d  = s_q;
          grant_d = 4'd0;
          state_d = IDLE;
        end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
          last_d    = s_q;
          grant_d   = 4'd0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s         = s_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = (state_q == GRANT);
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_sel4.sv
// Directed bench for rr_sel4 (TIMEOUT=4): a cycle-level priority model checked every cycle,
// plus hand-computed literal expectations along the test-plan scenarios.
module tb_rr_sel4;

  localparam int TO = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_sel4_if bus ();

  rr_sel4 #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who holds the mux, since which edge, and who was served last.
  bit model_on;
  bit m_busy;
  bit m_to;
  int m_sel;
  int m_last;
  int m_start;
  int edge_no;

  always @(posedge clk) begin
    edge_no++;
    if (!rst_n) begin
      model_on = 1'b1;
      m_busy   = 1'b0;
      m_to     = 1'b0;
      m_sel    = 0;
      m_last   = 3;
    end else begin
      m_to = 1'b0;
      if (m_busy) begin
        if (bus.out_ready) begin
          m_busy = 1'b0;
          m_last = m_sel;
        end else if (TO > 0 && (edge_no - m_start) == TO) begin
          m_busy = 1'b0;
          m_last = m_sel;
          m_to   = 1'b1;
        end
      end else if (bus.req != 4'd0) begin
        for (int k = 4; k >= 1; k--) begin
          if (bus.req[(m_last + k) % 4]) m_sel = (m_last + k) % 4;
        end
        m_busy  = 1'b1;
        m_start = edge_no;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_on) begin
      checks++;
      if (bus.out_valid !== m_busy || bus.s !== 2'(m_sel) || bus.timeout !== m_to ||
          bus.grant !== (m_busy ? (4'd1 << m_sel) : 4'd0)) begin
        errors++;
        $display("[TB] FAIL model t=%0t: got valid=%0b s=%0d grant=%b timeout=%0b, want valid=%0b s=%0d grant=%b timeout=%0b",
                 $time, bus.out_valid, bus.s, bus.grant, bus.timeout,
                 m_busy, m_sel, m_busy ? (4'd1 << m_sel) : 4'd0, m_to);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic rn);
    bus.req       = r;
    bus.out_ready = rdy;
    rst_n         = rn;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic v, input logic [1:0] s,
                             input logic [3:0] g, input logic t);
    checks++;
    if (bus.out_valid !== v || bus.s !== s || bus.grant !== g || bus.timeout !== t) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%0b s=%0d grant=%b timeout=%0b, want valid=%0b s=%0d grant=%b timeout=%0b",
               name, bus.out_valid, bus.s, bus.grant, bus.timeout, v, s, g, t);
    end
  endtask

  logic [1:0] fair_seq [4];
  logic [1:0] skip_seq [3];

  initial begin
    checks   = 0;
    errors   = 0;
    edge_no  = 0;
    model_on = 1'b0;
    fair_seq = '{2'd3, 2'd0, 2'd1, 2'd2};
    skip_seq = '{2'd1, 2'd3, 2'd1};

    applyStimulus(4'b0000, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("reset", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Single request on channel 2, consumer always ready: grant, idle, regrant.
    applyStimulus(4'b0100, 1'b1, 1'b1);
    stepCycle();
    checkOutput("single_grant", 1'b1, 2'd2, 4'b0100, 1'b0);
    stepCycle();
    checkOutput("single_idle", 1'b0, 2'd2, 4'b0000, 1'b0);
    stepCycle();
    checkOutput("single_regrant", 1'b1, 2'd2, 4'b0100, 1'b0);
    stepCycle();
    checkOutput("single_idle2", 1'b0, 2'd2, 4'b0000, 1'b0);

    // All requesting after channel 2 was served: rotation continues at 3.
    applyStimulus(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("fair_grant", 1'b1, fair_seq[i], 4'd1 << fair_seq[i], 1'b0);
      stepCycle();
      checkOutput("fair_idle", 1'b0, fair_seq[i], 4'b0000, 1'b0);
    end

    applyStimulus(4'b1000, 1'b1, 1'b1);
    stepCycle();
    checkOutput("serve3", 1'b1, 2'd3, 4'b1000, 1'b0);
    stepCycle();
    applyStimulus(4'b1010, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("wrap_skip", 1'b1, skip_seq[i], 4'd1 << skip_seq[i], 1'b0);
      stepCycle();
    end

    // Stall with channels 0 and 1 requesting; last served is 1 so channel 0 wins first.
    applyStimulus(4'b0011, 1'b0, 1'b1);
    for (int i = 0; i < TO; i++) begin
      stepCycle();
      checkOutput("stall_hold", 1'b1, 2'd0, 4'b0001, 1'b0);
    end
    stepCycle();
    checkOutput("timeout_pulse", 1'b0, 2'd0, 4'b0000, 1'b1);
    stepCycle();
    checkOutput("after_timeout", 1'b1, 2'd1, 4'b0010, 1'b0);

    applyStimulus(4'b1000, 1'b0, 1'b1);
    stepCycle();
    checkOutput("held_grant1", 1'b1, 2'd1, 4'b0010, 1'b0);
    stepCycle();
    checkOutput("held_grant2", 1'b1, 2'd1, 4'b0010, 1'b0);
    stepCycle();
    checkOutput("held_grant3", 1'b1, 2'd1, 4'b0010, 1'b0);
    applyStimulus(4'b1000, 1'b1, 1'b1);
    stepCycle();
    checkOutput("collision", 1'b0, 2'd1, 4'b0000, 1'b0);

    applyStimulus(4'b0100, 1'b0, 1'b1);
    stepCycle();
    checkOutput("pre_abort", 1'b1, 2'd2, 4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    stepCycle();
    checkOutput("abort_reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    stepCycle();
    checkOutput("post_reset", 1'b1, 2'd0, 4'b0001, 1'b0);
    stepCycle();
    checkOutput("post_reset_idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    stepCycle();
    checkOutput("post_reset_next", 1'b1, 2'd1, 4'b0010, 1'b0);

    applyStimulus(4'b0000, 1'b0, 1'b1);
    stepCycle();
    stepCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_sel4.md
# rr_sel4

Round-robin select generator that sits directly upstream of the 4:1 4-bit `mux4` datapath. It arbitrates among four requesting channels and drives the mux select `s`. It presents the selected channel through a valid/ready handshake, so the consumer of `mux4.y` knows when `y` is meaningful. A timeout releases a grant whose consumer never accepts, so one stalled channel cannot lock the mux.

## Interface
- `TIMEOUT`, default 16: maximum cycles a grant is held without handshake. Legal range 0..255; 0 disables the timeout.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `req` input 4: per-channel request; bit i corresponds to mux input a/b/c/d for i=0/1/2/3.
- `out_ready` input 1: consumer accepts the current selection.
- `s` output 2: mux select, connects to `mux4.s`; binary index of the granted channel.
- `grant` output 4: one-hot grant, equal to `1 << s` while `out_valid`=1, otherwise 0.
- `out_valid` output 1: selection is valid; `s` is stable while it is high.
- `timeout` output 1: one-cycle pulse when a grant is dropped by the timeout.

## Operation
- Two states:
  - IDLE: `out_valid`=0.
  - GRANT: `out_valid`=1.
- Internal registers: `last` (2b, last served index) and `wait_cnt` (8b).
- IDLE to GRANT: when `req`≠0, pick the first set bit scanning `last+1, last+2, last+3, last` (mod 4, wrap 3→0).
  - Load `s`, set `grant`, clear `wait_cnt`.
- In GRANT, `s` and `grant` are frozen. Changes on `req`, including deassertion of the granted bit, are ignored until release.
- Release by handshake: `out_valid`&&`out_ready` at an edge. Then `last`←`s`, go to IDLE.
- Release by timeout (TIMEOUT>0): `wait_cnt`==TIMEOUT-1 at an edge with `out_ready`=0.
  - `last`←`s` (the stalled channel loses priority), go to IDLE.
  - `timeout`=1 for the following cycle.
- Otherwise in GRANT, `wait_cnt` increments. It saturates at 255 when TIMEOUT=0.
- Handshake and timeout on the same edge: handshake wins, no `timeout` pulse.
- `s` keeps its last value in IDLE; it is not forced to 0. `grant` is 0 in IDLE.
- Reset (`rst_n`=0 at an edge, from any state):
  - state IDLE, `s`=0, `grant`=0, `out_valid`=0, `timeout`=0, `wait_cnt`=0.
  - `last`=3, so the first arbitration after reset favours channel 0.
- Reset mid-GRANT aborts the grant with no `timeout` pulse. `last` is not updated from the aborted grant.

## Timing
- All outputs are registered; there is no combinational path from `req`/`out_ready` to any output.
- Grant latency: `req`≠0 sampled in IDLE at edge N means `out_valid`=1 with valid `s` from edge N (visible in cycle N+1).
- Handshake at edge M means `out_valid`=0 in cycle M+1. The earliest next grant is visible in cycle M+2. Maximum throughput is one selection per 2 cycles.
- Timeout: grant visible from cycle G. With `out_ready` held 0, `out_valid` drops and `timeout`=1 in cycle G+TIMEOUT. With TIMEOUT=1, the grant lasts exactly one cycle.
- `timeout` is high for exactly one cycle and never coincides with `out_valid`=1.
- The `mux4` output `y` is valid in the same cycle as `out_valid` (the mux is combinational).

## Test plan
- Reset then single request:
  - Stimulus: `rst_n`=0 for 2 cycles, release, `req`=4'b0100, `out_ready`=1.
  - Required: `s`=2, `grant`=4'b0100, `out_valid`=1 for one cycle, then IDLE, then a regrant of channel 2 every 2 cycles. `y` equals input c (=2 with a..d=0..3).
- Round-robin fairness:
  - Stimulus: `req`=4'b1111, `out_ready`=1.
  - Required: grant sequence `s`=0,1,2,3,0,… with one IDLE cycle between grants. `y` follows 0,1,2,3.
- Wrap and skip:
  - Stimulus: after serving channel 3, `req`=4'b1010.
  - Required: next `s`=1, then 3, then 1.
- Stall and timeout with TIMEOUT=4:
  - Stimulus: `req`=4'b0011, `out_ready`=0.
  - Required: `s`=0 valid for exactly 4 cycles, then `timeout`=1 for 1 cycle with `out_valid`=0, then `s`=1 granted.
- Held grant and collision:
  - Stimulus: while `s`=1 is granted, drop `req[1]` and raise `req[3]`.
  - Required: `s` stays 1 until `out_ready`.
  - Stimulus: assert `out_ready` on the same edge where `wait_cnt`=TIMEOUT-1.
  - Required: handshake, no `timeout` pulse.
- Reset mid-grant:
  - Stimulus: `rst_n`=0 while `out_valid`=1 with `s`=2.
  - Required: next cycle all outputs 0 (`s`=0). With `req`=4'b1111 after release, the first grant is `s`=0.
